alu_ctrl_dcache: RTL and testbench
==================================

Name: alu_ctrl_dcache

Overview:
- Execute/memory slice of the single-cycle LEGv8-style datapath.
- Combines three parts:
  - an instruction decoder/controller;
  - a 32-bit ALU with a registered result and zero flag;
  - a word-addressed data cache.
- Sits between operand preparation (which supplies readData1/readData2) and register writeback (which consumes readData). The PC unit consumes the branch flags and zeroFlag.

Parameters:
- DEPTH, 64, number of 32-bit words in the data cache (power of two).
- AW, 6, log2(DEPTH); word index = result[AW+1:2].

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  32  current instruction word.
- readData1  in  32  ALU operand A.
- readData2  in  32  ALU operand B; also the store data.
- aluControlCode  in  4  ALU operation select.
- result  out  32  registered ALU result; also the data-cache byte address.
- zeroFlag  out  1  registered; 1 when result==0.
- readData  out  32  writeback data.
- unconditionalBranchFlag, branchFlag, memReadFlag, memToRegFlag, memWriteFlag, aluSRC, regWriteFlag  out  1 each  control flags.
- aluOP  out  2  00 load/store, 01 CBZ, 10 R-type.
- decodedAluCode  out  4  ALU code recommended by the decoder.
- readRegister1, readRegister2, writeRegister  out  5 each  register IDs.

Behaviour:
- Clocking and reset: one clock domain. While reset=1 (asynchronous, active-high):
  - result=0, zeroFlag=1;
  - all data-cache words=0.
- Controller (combinational, decodes instruction[31:21]):
  - LDUR 11111000010: memRead=1, memToReg=1, aluSRC=1, regWrite=1, aluOP=00, code 2.
  - STUR 11111000000: memWrite=1, aluSRC=1, aluOP=00, code 2.
  - ADD 10001011000: regWrite=1, aluOP=10, code 2.
  - SUB 11001011000: regWrite=1, aluOP=10, code 3.
  - AND 10001010000: regWrite=1, aluOP=10, code 6.
  - ORR 10101010000: regWrite=1, aluOP=10, code 4.
  - CBZ [31:24]=10110100: branch=1, aluOP=01, code 7.
  - B [31:26]=000101: unconditionalBranch=1, code 0.
  - Unlisted flags are 0 for each opcode.
  - Unknown opcode: every flag 0, aluOP=00, code 0.
  - CBZ and B are matched on their short prefixes and take priority over the 11-bit compares.
- Register IDs:
  - readRegister1 = instruction[9:5].
  - writeRegister = instruction[4:0].
  - readRegister2 = instruction[4:0] for STUR/CBZ, else instruction[20:16].
- ALU: each rising edge, result <= f(A=readData1, B=readData2, aluControlCode), and zeroFlag <= (f==0). Latency is 1 cycle.
  - 2: A+B (mod 2^32).
  - 3: A-B (two's complement).
  - 4: A|B.
  - 5: ~(A|B).
  - 6: A&B.
  - 7: B (CBZ pass-through; zeroFlag=1 iff B==0).
  - 9: A^B.
  - 12: ~(A&B).
  - 13: B (MOV).
  - Any other code: 0.
  - No carry or overflow outputs.
- Data cache:
  - Index = result[AW+1:2]; result[1:0] ignored; higher bits alias.
  - Write: on a rising edge with memWriteFlag=1, mem[index] <= readData2. The write uses the currently registered result as the address.
  - Read: combinational. memData = memReadFlag ? mem[index] : 0.
  - readData = memToRegFlag ? memData : result.
  - Read and write to the same index in the same cycle: readData shows the old word until the edge, the new word after it.
  - memWriteFlag is ignored while reset=1.
- Reset mid-operation clears result and memory immediately. Decode outputs are purely combinational and unaffected by reset.

Test Plan:
- ALU sweep: A=15, B=15.
  - code 2 -> 30, zeroFlag 0.
  - code 7 -> 15.
  - A=10, code 3 -> 0xFFFFFFFB.
  - A=5, code 6 -> 5.
  - code 4 -> 15.
  - B=10, code 9 -> 15.
  - code 5 -> 0xFFFFFFF0.
  - code 12 -> 0xFFFFFFFF.
  - code 13 -> 10.
  - Each result appears one edge after the inputs change.
- Zero flag: A=7, B=7, code 3 -> result 0, zeroFlag 1. Code 7 with B=0 -> zeroFlag 1. Undefined code 15 -> result 0, zeroFlag 1.
- Decode: apply the LDUR, STUR, ADD, SUB, AND, ORR, CBZ and B encodings plus 0x00000000.
  - Each must give exactly the flag, aluOP and decodedAluCode values listed in Behaviour.
  - STUR with instruction[4:0]=3, [20:16]=9 -> readRegister2=3. ADD with the same fields -> readRegister2=9.
- Store/load round trip:
  - Store: A=8, B=0, code 2 -> result 8. With memWriteFlag=1 (STUR) and readData2=0xDEADBEEF, one edge writes word 2.
  - Load: then decode LDUR with the same address; readData=0xDEADBEEF.
  - Alias: address 8+4*DEPTH reads the same word.
- Writeback mux: memToRegFlag=0 -> readData equals result. memReadFlag=0 with memToRegFlag=1 -> readData 0.
- Reset: assert reset asynchronously between edges after writes.
  - result and readData go to 0 and zeroFlag goes to 1 immediately.
  - After release, reading the previously written word returns 0.

Source files
------------

// File: rtl/alu_ctrl_dcache_if.sv
// Execute/memory bus of the LEGv8 slice: decoder inputs, ALU operands, and
// the control flags, register IDs, result and writeback data it produces.
interface alu_ctrl_dcache_if;
    logic [31:0] instruction;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [3:0]  aluControlCode;
    logic [31:0] result;
    logic        zeroFlag;
    logic [31:0] readData;
    logic        unconditionalBranchFlag;
    logic        branchFlag;
    logic        memReadFlag;
    logic        memToRegFlag;
    logic        memWriteFlag;
    logic        aluSRC;
    logic        regWriteFlag;
    logic [1:0]  aluOP;
    logic [3:0]  decodedAluCode;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [4:0]  writeRegister;

    modport slave (
        input  instruction, readData1, readData2, aluControlCode,
        output result, zeroFlag, readData,
        output unconditionalBranchFlag, branchFlag, memReadFlag, memToRegFlag,
        output memWriteFlag, aluSRC, regWriteFlag, aluOP, decodedAluCode,
        output readRegister1, readRegister2, writeRegister
    );

    modport master (
        output instruction, readData1, readData2, aluControlCode,
        input  result, zeroFlag, readData,
        input  unconditionalBranchFlag, branchFlag, memReadFlag, memToRegFlag,
        input  memWriteFlag, aluSRC, regWriteFlag, aluOP, decodedAluCode,
        input  readRegister1, readRegister2, writeRegister
    );
endinterface

// File: rtl/alu_ctrl_dcache.sv
// LEGv8 execute/memory slice: combinational decoder, registered 32-bit ALU,
// and a word-addressed data cache indexed by the registered ALU result.
module alu_ctrl_dcache #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input logic              clock,
    input logic              reset,
    alu_ctrl_dcache_if.slave bus
);
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    logic [10:0]   opcode;
    logic          is_cbz;
    logic          is_b;
    logic          rr2_from_rd;
    logic [31:0]   alu_f;
    logic [AW-1:0] idx;
    logic [31:0]   mem_data;
    logic [31:0]   mem [DEPTH];

    assign opcode = bus.instruction[31:21];
    assign is_cbz = (bus.instruction[31:24] == OP_CBZ);
    assign is_b   = (bus.instruction[31:26] == OP_B);

    // Short-prefix branches win over the 11-bit opcode compares.
    always_comb begin
        bus.unconditionalBranchFlag = 1'b0;
        bus.branchFlag              = 1'b0;
        bus.memReadFlag             = 1'b0;
        bus.memToRegFlag            = 1'b0;
        bus.memWriteFlag            = 1'b0;
        bus.aluSRC                  = 1'b0;
        bus.regWriteFlag            = 1'b0;
        bus.aluOP                   = 2'b00;
        bus.decodedAluCode          = 4'd0;
        rr2_from_rd                 = 1'b0;
        if (is_cbz) begin
            bus.branchFlag     = 1'b1;
            bus.aluOP          = 2'b01;
            bus.decodedAluCode = 4'd7;
            rr2_from_rd        = 1'b1;
        end else if (is_b) begin
            bus.unconditionalBranchFlag = 1'b1;
        end else begin
            case (opcode)
                OP_LDUR: begin
                    bus.memReadFlag    = 1'b1;
                    bus.memToRegFlag   = 1'b1;
                    bus.aluSRC         = 1'b1;
                    bus.regWriteFlag   = 1'b1;
                    bus.decodedAluCode = 4'd2;
                end
                OP_STUR: begin
                    bus.memWriteFlag   = 1'b1;
                    bus.aluSRC         = 1'b1;
                    bus.decodedAluCode = 4'd2;
                    rr2_from_rd        = 1'b1;
                end
                OP_ADD: begin
                    bus.regWriteFlag   = 1'b1;
                    bus.aluOP          = 2'b10;
                    bus.decodedAluCode = 4'd2;
                end
                OP_SUB: begin
                    bus.regWriteFlag   = 1'b1;
                    bus.aluOP          = 2'b10;
                    bus.decodedAluCode = 4'd3;
                end
                OP_AND: begin
                    bus.regWriteFlag   = 1'b1;
                    bus.aluOP          = 2'b10;
                    bus.decodedAluCode = 4'd6;
                end
                OP_ORR: begin
                    bus.regWriteFlag   = 1'b1;
                    bus.aluOP          = 2'b10;
                    bus.decodedAluCode = 4'd4;
                end
                default: ;
            endcase
        end
    end

    assign bus.readRegister1 = bus.instruction[9:5];
    assign bus.writeRegister = bus.instruction[4:0];
    assign bus.readRegister2 = rr2_from_rd ? bus.instruction[4:0] : bus.instruction[20:16];

    always_comb begin
        alu_f = '0;
        case (bus.aluControlCode)
            4'd2:    alu_f = bus.readData1 + bus.readData2;
            4'd3:    alu_f = bus.readData1 - bus.readData2;
            4'd4:    alu_f = bus.readData1 | bus.readData2;
            4'd5:    alu_f = ~(bus.readData1 | bus.readData2);
            4'd6:    alu_f = bus.readData1 & bus.readData2;
            4'd7:    alu_f = bus.readData2;
            4'd9:    alu_f = bus.readData1 ^ bus.readData2;
            4'd12:   alu_f = ~(bus.readData1 & bus.readData2);
            4'd13:   alu_f = bus.readData2;
            default: alu_f = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.result   <= '0;
            bus.zeroFlag <= 1'b1;
        end else begin
            bus.result   <= alu_f;
            bus.zeroFlag <= (alu_f == 32'd0);
        end
    end

    // Byte address from the registered result; low two bits and high bits ignored.
    assign idx = bus.result[AW+1:2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.memWriteFlag) begin
            mem[idx] <= bus.readData2;
        end
    end

    assign mem_data     = bus.memReadFlag ? mem[idx] : '0;
    assign bus.readData = bus.memToRegFlag ? mem_data : bus.result;
endmodule

// File: tb/tb_alu_ctrl_dcache.sv
// Self-checking bench for alu_ctrl_dcache: directed plan steps followed by a
// randomized run checked against a behavioural model of ALU, decoder and cache.
module tb_alu_ctrl_dcache;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_ctrl_dcache_if bus ();
    alu_ctrl_dcache #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mres;
    logic [31:0] mmem [DEPTH];

    // Expected decode as {ub, br, mr, m2r, mw, asrc, rw, aluop[1:0], code[3:0]}.
    function automatic logic [12:0] dec_ref(input logic [31:0] ins);
        if (ins[31:24] == 8'hB4)        return {7'b0100000, 2'b01, 4'd7};
        if (ins[31:26] == 6'b000101)    return {7'b1000000, 2'b00, 4'd0};
        if (ins[31:21] == OP_LDUR)      return {7'b0011011, 2'b00, 4'd2};
        if (ins[31:21] == OP_STUR)      return {7'b0000110, 2'b00, 4'd2};
        if (ins[31:21] == OP_ADD)       return {7'b0000001, 2'b10, 4'd2};
        if (ins[31:21] == OP_SUB)       return {7'b0000001, 2'b10, 4'd3};
        if (ins[31:21] == OP_AND)       return {7'b0000001, 2'b10, 4'd6};
        if (ins[31:21] == OP_ORR)       return {7'b0000001, 2'b10, 4'd4};
        return 13'd0;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] code);
        case (code)
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return a | b;
            4'd5:    return ~(a | b);
            4'd6:    return a & b;
            4'd7:    return b;
            4'd9:    return a ^ b;
            4'd12:   return ~(a & b);
            4'd13:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] rd_ref();
        logic [12:0] d;
        d = dec_ref(bus.instruction);
        if (!d[9]) return mres;
        return d[10] ? mmem[widx(mres)] : 32'd0;
    endfunction

    function automatic logic [31:0] mk(input logic [10:0] op, input logic [4:0] rm,
                                       input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge; the model applies the store with the old result, then the ALU.
    task automatic cycle();
        if (dec_ref(bus.instruction)[8]) mmem[widx(mres)] = bus.readData2;
        mres = alu_ref(bus.readData1, bus.readData2, bus.aluControlCode);
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] code);
        bus.readData1      = a;
        bus.readData2      = b;
        bus.aluControlCode = code;
    endtask

    task automatic alu_step(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] code, input logic [31:0] exp, input logic zf);
        drive(a, b, code);
        cycle();
        check({tag, ".result"}, bus.result, exp);
        check({tag, ".zero"}, 32'(bus.zeroFlag), 32'(zf));
    endtask

    task automatic check_all(input string tag);
        logic [12:0] d;
        logic        rr2_rd;
        d      = dec_ref(bus.instruction);
        rr2_rd = (bus.instruction[31:21] == OP_STUR) || (bus.instruction[31:24] == 8'hB4);
        check({tag, ".result"}, bus.result, mres);
        check({tag, ".zero"}, 32'(bus.zeroFlag), 32'(mres == 32'd0));
        check({tag, ".readData"}, bus.readData, rd_ref());
        check({tag, ".decode"},
              32'({bus.unconditionalBranchFlag, bus.branchFlag, bus.memReadFlag,
                   bus.memToRegFlag, bus.memWriteFlag, bus.aluSRC, bus.regWriteFlag,
                   bus.aluOP, bus.decodedAluCode}), 32'(d));
        check({tag, ".rr1"}, 32'(bus.readRegister1), 32'(bus.instruction[9:5]));
        check({tag, ".rr2"}, 32'(bus.readRegister2),
              32'(rr2_rd ? bus.instruction[4:0] : bus.instruction[20:16]));
        check({tag, ".wr"}, 32'(bus.writeRegister), 32'(bus.instruction[4:0]));
    endtask

    initial begin
        logic [31:0] ins_list [9];
        logic [31:0] r;
        int          sel;

        reset = 1'b1;
        bus.instruction = 32'd0;
        drive(32'd0, 32'd0, 4'd0);
        mres = 32'd0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset.result", bus.result, 32'd0);
        check("reset.zero", 32'(bus.zeroFlag), 32'd1);
        check("reset.readData", bus.readData, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // ALU sweep with a non-memory instruction; first step also checks latency.
        drive(32'd15, 32'd15, 4'd2);
        #1;
        check("latency.before_edge", bus.result, 32'd0);
        alu_step("alu.add", 32'd15, 32'd15, 4'd2, 32'd30, 1'b0);
        alu_step("alu.cbz_pass", 32'd15, 32'd15, 4'd7, 32'd15, 1'b0);
        alu_step("alu.sub", 32'd10, 32'd15, 4'd3, 32'hFFFF_FFFB, 1'b0);
        alu_step("alu.and", 32'd5, 32'd15, 4'd6, 32'd5, 1'b0);
        alu_step("alu.or", 32'd5, 32'd15, 4'd4, 32'd15, 1'b0);
        alu_step("alu.xor", 32'd5, 32'd10, 4'd9, 32'd15, 1'b0);
        alu_step("alu.nor", 32'd5, 32'd10, 4'd5, 32'hFFFF_FFF0, 1'b0);
        alu_step("alu.nand", 32'd5, 32'd10, 4'd12, 32'hFFFF_FFFF, 1'b0);
        alu_step("alu.mov", 32'd5, 32'd10, 4'd13, 32'd10, 1'b0);
        alu_step("zero.sub", 32'd7, 32'd7, 4'd3, 32'd0, 1'b1);
        alu_step("zero.cbz", 32'd7, 32'd0, 4'd7, 32'd0, 1'b1);
        alu_step("zero.undef", 32'd1, 32'd1, 4'd15, 32'd0, 1'b1);

        // Decode table, including the unknown all-zero word.
        ins_list[0] = mk(OP_LDUR, 5'd9, 5'd2, 5'd3);
        ins_list[1] = mk(OP_STUR, 5'd9, 5'd2, 5'd3);
        ins_list[2] = mk(OP_ADD, 5'd9, 5'd2, 5'd3);
        ins_list[3] = mk(OP_SUB, 5'd9, 5'd2, 5'd3);
        ins_list[4] = mk(OP_AND, 5'd9, 5'd2, 5'd3);
        ins_list[5] = mk(OP_ORR, 5'd9, 5'd2, 5'd3);
        ins_list[6] = 32'hB400_0123;
        ins_list[7] = 32'h1400_0040;
        ins_list[8] = 32'h0000_0000;
        for (int i = 0; i < 9; i++) begin
            bus.instruction = ins_list[i];
            #1;
            check($sformatf("decode%0d", i), 32'({bus.unconditionalBranchFlag, bus.branchFlag,
                  bus.memReadFlag, bus.memToRegFlag, bus.memWriteFlag, bus.aluSRC,
                  bus.regWriteFlag, bus.aluOP, bus.decodedAluCode}), 32'(dec_ref(ins_list[i])));
        end
        bus.instruction = ins_list[1];
        #1;
        check("rr2.stur", 32'(bus.readRegister2), 32'd3);
        bus.instruction = ins_list[2];
        #1;
        check("rr2.add", 32'(bus.readRegister2), 32'd9);

        // Store/load round trip at byte address 8 (word 2), then alias.
        bus.instruction = ins_list[2];
        alu_step("st.addr", 32'd8, 32'd0, 4'd2, 32'd8, 1'b0);
        bus.instruction = ins_list[1];
        alu_step("st.write", 32'd8, 32'hDEAD_BEEF, 4'd6, 32'd8, 1'b0);
        bus.instruction = ins_list[0];
        #1;
        check("ld.word2", bus.readData, 32'hDEAD_BEEF);
        alu_step("ld.alias_addr", 32'd8 + 32'(4 * DEPTH), 32'd0, 4'd2, 32'd8 + 32'(4 * DEPTH), 1'b0);
        check("ld.alias", bus.readData, 32'hDEAD_BEEF);
        bus.instruction = ins_list[2];
        #1;
        check("wb.result", bus.readData, bus.result);
        check("wb.value", bus.readData, 32'd8 + 32'(4 * DEPTH));

        // Asynchronous reset between edges clears result and memory at once.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("areset.result", bus.result, 32'd0);
        check("areset.zero", 32'(bus.zeroFlag), 32'd1);
        check("areset.readData", bus.readData, 32'd0);
        mres = 32'd0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        bus.instruction = ins_list[0];
        alu_step("postreset.addr", 32'd8, 32'd0, 4'd2, 32'd8, 1'b0);
        check("postreset.load", bus.readData, 32'd0);

        // Randomized traffic against the model; small addresses raise hit rate.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            r   = $urandom();
            case (sel)
                0, 1:    bus.instruction = {OP_LDUR, r[20:0]};
                2, 3:    bus.instruction = {OP_STUR, r[20:0]};
                4:       bus.instruction = {OP_ADD, r[20:0]};
                5:       bus.instruction = {OP_SUB, r[20:0]};
                6:       bus.instruction = {($urandom_range(0, 1) != 0) ? OP_AND : OP_ORR, r[20:0]};
                7:       bus.instruction = {8'hB4, r[23:0]};
                8:       bus.instruction = {6'b000101, r[25:0]};
                default: bus.instruction = r;
            endcase
            if ($urandom_range(0, 3) == 0)
                drive($urandom(), $urandom(), 4'($urandom_range(0, 15)));
            else
                drive(32'($urandom_range(0, 1023)), 32'($urandom_range(0, 3)) == 0 ? 32'd0 : $urandom(),
                      4'($urandom_range(0, 15)));
            #1;
            check_all("rand.pre");
            cycle();
            check_all("rand.post");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
